cv32e40p_obi_dp_ram: RTL
========================

// Module: cv32e40p_obi_dp_ram
// PURPOSE
//  Dual-port OBI slave RAM serving the core's instruction and data interfaces.
//  Successor to the single-latency testbench memory: adds parametrised
//  grant->rvalid latency, an outstanding-transaction limit and optional
//  pseudo-random grant stalls to stress the core's LSU/prefetcher.
//  Sits between cv32e40p_core and the MMIO decode; MMIO addresses never reach it.
// PARAMETERS
//  ADDR_WIDTH      17        byte-address width of the RAM (size = 2**ADDR_WIDTH bytes)
//  DATA_WIDTH      32        word width; multiple of 8, power of 2
//  RD_LATENCY      1         cycles from granted req to rvalid; legal 1..4
//  MAX_OUTSTANDING 2         granted-but-unanswered transactions per port; 1..RD_LATENCY+1
//  GNT_STALL_EN    0         1: LFSR-driven grant stalls enabled
//  STALL_SEED      16'hACE1  LFSR reset value (instr port; data port uses ~STALL_SEED)
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           async active-low reset
//  instr_req_i    in   1           instr request (read-only port)
//  instr_gnt_o    out  1           instr grant
//  instr_addr_i   in   ADDR_WIDTH  instr byte address
//  instr_rdata_o  out  DATA_WIDTH  instr read data
//  instr_rvalid_o out  1           instr response valid
//  data_req_i     in   1           data request
//  data_gnt_o     out  1           data grant
//  data_addr_i    in   32          data byte address
//  data_we_i      in   1           1 = write
//  data_be_i      in   DATA_WIDTH/8 byte enables
//  data_wdata_i   in   DATA_WIDTH  write data
//  data_rdata_o   out  DATA_WIDTH  read data
//  data_rvalid_o  out  1           data response valid (reads and writes)
//  oob_o          out  1           sticky: data access at addr >= 2**ADDR_WIDTH seen
// BEHAVIOUR
//  - Reset: all gnt/rvalid/oob_o = 0, rdata = 0, counters 0, LFSRs = seed; RAM contents NOT reset.
//  - Word index = addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; low bits ignored.
//  - gnt_o (combinational, per port) = req & (outstanding < MAX_OUTSTANDING) & ~stall.
//    outstanding counts granted txns whose rvalid has not yet been issued; a response
//    retiring this cycle does not free a slot until next cycle.
//  - Transaction accepted on req&gnt at edge N; RAM read/write performed at edge N;
//    rvalid high for exactly one cycle after edge N+RD_LATENCY-1 (RD_LATENCY=1: cycle after grant).
//  - Responses strictly in order per port; pipeline = RD_LATENCY-deep shift of {valid,data}.
//  - Writes: bytes with be=1 updated; rvalid returned with rdata = 0. be=0000 -> no update, still rvalid.
//  - rdata_o holds last response value when rvalid=0 (no forced zero).
//  - Data port out-of-range (addr[31:ADDR_WIDTH] != 0): granted normally, write dropped,
//    read returns 0, oob_o set and held until reset.
//  - Same-word collision (data write + instr read same edge): instr gets OLD data;
//    data write takes effect; data read+write on different ports never conflict otherwise.
//  - Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle; stall = GNT_STALL_EN
//    & (lfsr[1:0]==2'b00) (~25%). GNT_STALL_EN=0 -> stall tied 0, LFSR may be pruned.
//  - Reset asserted mid-operation: in-flight responses discarded (no rvalid after release),
//    outstanding counts cleared, partially pipelined writes already committed stay committed.
//  - Ports fully independent; no cross-port arbitration.
// TESTING
//  T1 RD_LATENCY=1: data write 0xDEADBEEF @0x100 be=1111, then read @0x100 -> rvalid next cycle, rdata=0xDEADBEEF.
//  T2 be=0010 write 0x0000AA00 over 0x11223344 -> readback 0x1122AA44; be=0000 -> unchanged, rvalid still 1.
//  T3 RD_LATENCY=3, MAX_OUTSTANDING=2: hold instr_req 1 -> gnt 2 cycles, 0 until first rvalid retires; order kept.
//  T4 same edge: data write 0x55 @0x40 + instr read @0x40 (old 0x12) -> instr_rdata=0x12; next read -> 0x55.
//  T5 data read @0x0002_0000 (ADDR_WIDTH=17) -> rvalid, rdata=0, oob_o=1 sticky until rst_ni=0.
//  T6 GNT_STALL_EN=1, 1000 back-to-back reads: gnt low ~25% (200..300 cycles), data matches model;
//     rst_ni pulsed with 2 txns in flight -> no rvalid after release, next txn normal.

Source files
------------

// File: rtl/cv32e40p_obi_dp_ram.sv
// rtl/cv32e40p_obi_dp_ram.sv - dual-port OBI slave RAM with response latency, outstanding limit and grant stalls
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   instr_req_i / instr_gnt_o          instruction port handshake (read-only)
//   instr_addr_i                       instruction byte address (ADDR_WIDTH bits)
//   instr_rdata_o / instr_rvalid_o     instruction response
//   data_req_i / data_gnt_o            data port handshake
//   data_addr_i                        data byte address (full 32 bits, range checked)
//   data_we_i, data_be_i, data_wdata_i data write controls
//   data_rdata_o / data_rvalid_o       data response (reads and writes)
//   oob_o                              sticky flag: data access beyond the RAM seen
module cv32e40p_obi_dp_ram #(
    parameter int unsigned ADDR_WIDTH      = 17,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          GNT_STALL_EN    = 1'b0,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    output logic                    instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    output logic                    instr_rvalid_o,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [31:0]             data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_rvalid_o,
    output logic                    oob_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF      = $clog2(BE_WIDTH);
    localparam int unsigned IDX_W    = ADDR_WIDTH - OFF;
    localparam int unsigned WORDS    = 1 << IDX_W;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    // Storage is deliberately never reset: contents survive a reset pulse.
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [IDX_W-1:0] instr_idx;
    logic [IDX_W-1:0] data_idx;
    logic             data_oob;
    logic             unused_addr_lsbs;

    assign instr_idx        = instr_addr_i[ADDR_WIDTH-1:OFF];
    assign data_idx         = data_addr_i[ADDR_WIDTH-1:OFF];
    assign unused_addr_lsbs = ^{instr_addr_i[OFF-1:0], data_addr_i[OFF-1:0]};

    generate
        if (ADDR_WIDTH < 32) begin : g_oob
            assign data_oob = |data_addr_i[31:ADDR_WIDTH];
        end else begin : g_no_oob
            assign data_oob = 1'b0;
        end
    endgenerate

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form, feedback into bit 15).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [15:0] instr_lfsr_q;
    logic [15:0] data_lfsr_q;
    logic        instr_stall;
    logic        data_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_lfsr_q <= STALL_SEED;
            data_lfsr_q  <= ~STALL_SEED;
        end else begin
            instr_lfsr_q <= lfsr_step(instr_lfsr_q);
            data_lfsr_q  <= lfsr_step(data_lfsr_q);
        end
    end

    assign instr_stall = GNT_STALL_EN && (instr_lfsr_q[1:0] == 2'b00);
    assign data_stall  = GNT_STALL_EN && (data_lfsr_q[1:0] == 2'b00);

    // Outstanding = granted but rvalid not yet issued. The response visible this
    // cycle is still counted, so a retiring slot only frees up next cycle.
    logic [CNT_W-1:0] instr_cnt_q;
    logic [CNT_W-1:0] data_cnt_q;
    logic             instr_acc;
    logic             data_acc;

    assign instr_gnt_o = rst_ni & instr_req_i & (instr_cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~instr_stall;
    assign data_gnt_o  = rst_ni & data_req_i & (data_cnt_q < CNT_W'(MAX_OUTSTANDING)) & ~data_stall;
    assign instr_acc   = instr_req_i & instr_gnt_o;
    assign data_acc    = data_req_i & data_gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_cnt_q <= '0;
            data_cnt_q  <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_q + CNT_W'(instr_acc) - CNT_W'(instr_rvalid_o);
            data_cnt_q  <= data_cnt_q + CNT_W'(data_acc) - CNT_W'(data_rvalid_o);
        end
    end

    // Byte-masked write; out-of-range writes are dropped rather than aliased.
    always_ff @(posedge clk_i) begin
        if (data_acc && data_we_i && !data_oob) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (data_be_i[b]) begin
                    mem[data_idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Response pipelines. A stage loads only when valid data arrives, so the
    // last stage doubles as the held rdata output between responses.
    logic [RD_LATENCY-1:0] instr_vld_q;
    logic [RD_LATENCY-1:0] data_vld_q;
    logic [DATA_WIDTH-1:0] instr_dat_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_dat_q  [RD_LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_vld_q <= '0;
            data_vld_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                instr_dat_q[i] <= '0;
                data_dat_q[i]  <= '0;
            end
        end else begin
            instr_vld_q[0] <= instr_acc;
            data_vld_q[0]  <= data_acc;
            // Non-blocking read of mem gives the pre-write word on a same-edge collision.
            if (instr_acc) begin
                instr_dat_q[0] <= mem[instr_idx];
            end
            if (data_acc) begin
                data_dat_q[0] <= (data_we_i || data_oob) ? '0 : mem[data_idx];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                instr_vld_q[i] <= instr_vld_q[i-1];
                data_vld_q[i]  <= data_vld_q[i-1];
                if (instr_vld_q[i-1]) begin
                    instr_dat_q[i] <= instr_dat_q[i-1];
                end
                if (data_vld_q[i-1]) begin
                    data_dat_q[i] <= data_dat_q[i-1];
                end
            end
        end
    end

    assign instr_rvalid_o = instr_vld_q[RD_LATENCY-1];
    assign instr_rdata_o  = instr_dat_q[RD_LATENCY-1];
    assign data_rvalid_o  = data_vld_q[RD_LATENCY-1];
    assign data_rdata_o   = data_dat_q[RD_LATENCY-1];

    logic oob_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oob_q <= 1'b0;
        end else if (data_acc && data_oob) begin
            oob_q <= 1'b1;
        end
    end

    assign oob_o = oob_q;

endmodule
